// File: rtl/edge_frame_host.sv
// Host-side frame engine for the EdgeDetector: packs a pixel stream into a word buffer,
// streams the buffer out under chipSelect, then captures the result stream into a RAM port.
module edge_frame_host #(
    parameter int IMG_PIXELS   = 1024,
    parameter int NUM_RESULTS  = 1352,
    parameter int DONE_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  pixIn,
    input  logic        pixValid,
    output logic        pixReady,
    output logic        chipSelect,
    output logic [31:0] readMem,
    input  logic        finalConvDone,
    input  logic [15:0] writeMem,
    output logic        resWrEn,
    output logic [10:0] resAddr,
    output logic [15:0] resData,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int WORDS  = IMG_PIXELS / 4;
    localparam int PIX_W  = $clog2(IMG_PIXELS);
    localparam int WORD_W = $clog2(WORDS);
    localparam int RES_W  = $clog2(NUM_RESULTS);
    localparam int WAIT_W = $clog2(DONE_TIMEOUT + 1);
    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(IMG_PIXELS - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS - 1);
    localparam logic [RES_W-1:0]  RES_LAST  = RES_W'(NUM_RESULTS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DONE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_STREAM  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_FINISH  = 3'd5
    } state_t;

    state_t             state_r, state_next_s;
    logic [PIX_W-1:0]   pix_cnt_r, pix_cnt_next_s;
    logic [WORD_W-1:0]  rd_idx_r, rd_idx_next_s, rd_inc_s;
    logic [WAIT_W-1:0]  wait_cnt_r, wait_cnt_next_s;
    logic [RES_W-1:0]   res_idx_r, res_idx_next_s;
    logic [23:0]        byte_sr_r, byte_sr_next_s;
    logic               pix_ready_r, pix_ready_next_s;
    logic               chip_sel_r, chip_sel_next_s;
    logic [31:0]        read_mem_r, read_mem_next_s;
    logic               res_wr_en_r, res_wr_en_next_s;
    logic [10:0]        res_addr_r, res_addr_next_s;
    logic [15:0]        res_data_r, res_data_next_s;
    logic               busy_r, busy_next_s;
    logic               done_r, done_next_s;
    logic               err_r, err_next_s;
    logic               accept_s, cap_s, wr_en_s;
    logic [31:0]        wr_data_s;
    logic [WORD_W-1:0]  wr_addr_s;
    logic [31:0]        mem_r [WORDS];

    // Next-state and next-output logic for the frame sequencer
    always_comb begin
        state_next_s     = state_r;
        pix_cnt_next_s   = pix_cnt_r;
        rd_idx_next_s    = rd_idx_r;
        wait_cnt_next_s  = wait_cnt_r;
        res_idx_next_s   = res_idx_r;
        byte_sr_next_s   = byte_sr_r;
        pix_ready_next_s = pix_ready_r;
        chip_sel_next_s  = chip_sel_r;
        read_mem_next_s  = read_mem_r;
        res_wr_en_next_s = 1'b0;
        res_addr_next_s  = res_addr_r;
        res_data_next_s  = res_data_r;
        done_next_s      = 1'b0;
        err_next_s       = err_r;
        rd_inc_s         = rd_idx_r + WORD_W'(1);
        // pixReady is only ever high in FILL, so it alone qualifies acceptance
        accept_s         = pix_ready_r && pixValid;
        cap_s            = finalConvDone && ((state_r == ST_WAIT) || (state_r == ST_CAPTURE));
        wr_en_s          = accept_s && (pix_cnt_r[1:0] == 2'b11);
        wr_addr_s        = pix_cnt_r[PIX_W-1:2];
        wr_data_s        = {pixIn, byte_sr_r};

        if (accept_s) begin
            byte_sr_next_s = {pixIn, byte_sr_r[23:8]};
        end else begin
            byte_sr_next_s = byte_sr_r;
        end

        if (cap_s) begin
            res_data_next_s  = writeMem;
            res_addr_next_s  = 11'(res_idx_r);
            res_wr_en_next_s = 1'b1;
            res_idx_next_s   = res_idx_r + RES_W'(1);
        end else begin
            res_wr_en_next_s = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s     = ST_FILL;
                    pix_cnt_next_s   = '0;
                    rd_idx_next_s    = '0;
                    wait_cnt_next_s  = '0;
                    res_idx_next_s   = '0;
                    err_next_s       = 1'b0;
                    pix_ready_next_s = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (accept_s && (pix_cnt_r == PIX_LAST)) begin
                    state_next_s     = ST_STREAM;
                    pix_ready_next_s = 1'b0;
                    chip_sel_next_s  = 1'b1;
                    rd_idx_next_s    = '0;
                    read_mem_next_s  = mem_r[0];
                end else if (accept_s) begin
                    pix_cnt_next_s = pix_cnt_r + PIX_W'(1);
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_STREAM: begin
                if (rd_idx_r == WORD_LAST) begin
                    state_next_s    = ST_WAIT;
                    wait_cnt_next_s = '0;
                end else begin
                    rd_idx_next_s   = rd_inc_s;
                    read_mem_next_s = mem_r[rd_inc_s];
                end
            end
            ST_WAIT: begin
                if (cap_s) begin
                    state_next_s = (res_idx_r == RES_LAST) ? ST_FINISH : ST_CAPTURE;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_next_s    = ST_IDLE;
                    err_next_s      = 1'b1;
                    chip_sel_next_s = 1'b0;
                    done_next_s     = 1'b1;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + WAIT_W'(1);
                end
            end
            ST_CAPTURE: begin
                if (cap_s && (res_idx_r == RES_LAST)) begin
                    state_next_s = ST_FINISH;
                end else begin
                    state_next_s = ST_CAPTURE;
                end
            end
            ST_FINISH: begin
                state_next_s    = ST_IDLE;
                chip_sel_next_s = 1'b0;
                done_next_s     = 1'b1;
            end
            default: begin
                state_next_s     = ST_IDLE;
                pix_ready_next_s = 1'b0;
                chip_sel_next_s  = 1'b0;
            end
        endcase

        busy_next_s = (state_next_s != ST_IDLE);
    end

    // State, counter and output registers; reset overrides everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            pix_cnt_r   <= '0;
            rd_idx_r    <= '0;
            wait_cnt_r  <= '0;
            res_idx_r   <= '0;
            byte_sr_r   <= 24'h000000;
            pix_ready_r <= 1'b0;
            chip_sel_r  <= 1'b0;
            read_mem_r  <= 32'h00000000;
            res_wr_en_r <= 1'b0;
            res_addr_r  <= 11'd0;
            res_data_r  <= 16'h0000;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            pix_cnt_r   <= pix_cnt_next_s;
            rd_idx_r    <= rd_idx_next_s;
            wait_cnt_r  <= wait_cnt_next_s;
            res_idx_r   <= res_idx_next_s;
            byte_sr_r   <= byte_sr_next_s;
            pix_ready_r <= pix_ready_next_s;
            chip_sel_r  <= chip_sel_next_s;
            read_mem_r  <= read_mem_next_s;
            res_wr_en_r <= res_wr_en_next_s;
            res_addr_r  <= res_addr_next_s;
            res_data_r  <= res_data_next_s;
            busy_r      <= busy_next_s;
            done_r      <= done_next_s;
            err_r       <= err_next_s;
        end
    end

    // Frame buffer write port; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end
    end

    assign pixReady   = pix_ready_r;
    assign chipSelect = chip_sel_r;
    assign readMem    = read_mem_r;
    assign resWrEn    = res_wr_en_r;
    assign resAddr    = res_addr_r;
    assign resData    = res_data_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
endmodule

// File: tb/tb_edge_frame_host.sv
// Directed bench for edge_frame_host: packing, backpressure, capture, pause, timeout and reset.
module tb_edge_frame_host;
    logic        clk = 1'b0;
    logic        reset, start, pixValid, finalConvDone;
    logic [7:0]  pixIn;
    logic [15:0] writeMem;
    logic        pixReady, chipSelect, resWrEn, busy, done, err;
    logic [31:0] readMem;
    logic [10:0] resAddr;
    logic [15:0] resData;
    int          checks = 0;
    int          failures = 0;

    edge_frame_host #(
        .IMG_PIXELS   (1024),
        .NUM_RESULTS  (1352),
        .DONE_TIMEOUT (20)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .pixIn         (pixIn),
        .pixValid      (pixValid),
        .pixReady      (pixReady),
        .chipSelect    (chipSelect),
        .readMem       (readMem),
        .finalConvDone (finalConvDone),
        .writeMem      (writeMem),
        .resWrEn       (resWrEn),
        .resAddr       (resAddr),
        .resData       (resData),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int k);
        logic [7:0] b;
        b = 8'(4 * k);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    // Start a frame (with a pixel offered on the start cycle) and feed 1024 pixels
    task automatic fill_frame(input bit bp);
        int n;
        int guard;
        bit v;
        bit rdy;
        start = 1'b1; pixValid = 1'b1; pixIn = 8'hAA;
        tick();
        start = 1'b0;
        chk("fill_ready", pixReady, 1);
        chk("fill_busy", busy, 1);
        n = 0; guard = 0; v = 1'b1;
        while (n < 1024 && guard < 4000) begin
            pixIn = 8'(n);
            pixValid = bp ? v : 1'b1;
            rdy = pixReady;
            tick();
            if (rdy && pixValid) n++;
            v = ~v;
            guard++;
        end
        pixValid = 1'b0;
        chk("fill_count", n, 1024);
        chk("fill_end_ready", pixReady, 0);
        chk("fill_end_cs", chipSelect, 1);
    endtask

    // Expect the 256 packed words on consecutive cycles, then the hold in WAIT_DONE
    task automatic stream_frame();
        for (int k = 0; k < 256; k++) begin
            chk($sformatf("word%0d", k), readMem, exp_word(k));
            if (k % 64 == 0) begin
                chk($sformatf("stream_ready%0d", k), pixReady, 0);
                chk($sformatf("stream_cs%0d", k), chipSelect, 1);
            end
            tick();
        end
        chk("wait_hold_word", readMem, 32'hFFFEFDFC);
        chk("wait_cs", chipSelect, 1);
        chk("wait_busy", busy, 1);
    endtask

    // Feed 1352 results, optionally pausing 5 cycles before result pause_at
    task automatic capture_frame(input int pause_at);
        for (int i = 0; i < 1352; i++) begin
            if (i == pause_at) begin
                for (int g = 0; g < 5; g++) begin
                    finalConvDone = 1'b0;
                    writeMem = 16'hBEEF;
                    tick();
                    chk($sformatf("pause_wr%0d", g), resWrEn, 0);
                end
            end
            finalConvDone = 1'b1;
            writeMem = 16'(i + 256);
            tick();
            chk($sformatf("cap_we%0d", i), resWrEn, 1);
            chk($sformatf("cap_addr%0d", i), resAddr, 32'(i));
            chk($sformatf("cap_data%0d", i), resData, 32'(i + 256));
        end
        finalConvDone = 1'b1;
        writeMem = 16'hDEAD;
        chk("finish_busy", busy, 1);
        chk("finish_done_low", done, 0);
        tick();
        chk("end_done", done, 1);
        chk("end_we", resWrEn, 0);
        chk("end_cs", chipSelect, 0);
        chk("end_busy", busy, 0);
        chk("end_addr", resAddr, 32'd1351);
        chk("end_data", resData, 32'h0647);
        tick();
        chk("after_done", done, 0);
        chk("after_we", resWrEn, 0);
        chk("after_data", resData, 32'h0647);
        finalConvDone = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; pixValid = 1'b0; pixIn = 8'h00;
        finalConvDone = 1'b0; writeMem = 16'h0000;
        tick(); tick(); tick();
        chk("rst_ready", pixReady, 0);
        chk("rst_cs", chipSelect, 0);
        chk("rst_rdmem", readMem, 0);
        chk("rst_we", resWrEn, 0);
        chk("rst_addr", resAddr, 0);
        chk("rst_data", resData, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        pixValid = 1'b1;
        tick();
        chk("idle_ready", pixReady, 0);
        chk("idle_busy", busy, 0);
        pixValid = 1'b0;

        // packing with continuous pixels, then a full result capture
        fill_frame(1'b0);
        stream_frame();
        capture_frame(-1);

        // backpressure fill, capture with a pause after 100 results
        tick();
        fill_frame(1'b1);
        stream_frame();
        capture_frame(100);

        // timeout with finalConvDone never asserted
        tick();
        fill_frame(1'b0);
        stream_frame();
        for (int j = 1; j < 20; j++) begin
            tick();
            if (j == 1 || j == 19) begin
                chk($sformatf("to_err_low%0d", j), err, 0);
                chk($sformatf("to_cs%0d", j), chipSelect, 1);
            end
        end
        tick();
        chk("to_err", err, 1);
        chk("to_done", done, 1);
        chk("to_cs_low", chipSelect, 0);
        chk("to_busy", busy, 0);
        tick();
        chk("to_done_pulse", done, 0);
        chk("to_err_sticky", err, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_err_clr", err, 0);
        chk("restart_busy", busy, 1);

        // mid-stream reset aborts the frame
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fill_frame(1'b0);
        for (int k = 0; k < 10; k++) tick();
        chk("mid_cs", chipSelect, 1);
        reset = 1'b1;
        tick();
        chk("mrst_cs", chipSelect, 0);
        chk("mrst_rdmem", readMem, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", pixReady, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_cs", chipSelect, 0);
        chk("post_rst_ready", pixReady, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
